// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// datapath select codes and trap causes.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_UPPER  = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_IMM  = 2'b10;
  localparam logic [1:0] RES_LINK = 2'b11;

  localparam logic [2:0] IMM_NONE  = 3'b000;
  localparam logic [2:0] IMM_I     = 3'b001;
  localparam logic [2:0] IMM_SHAMT = 3'b010;
  localparam logic [2:0] IMM_S     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_B     = 3'b101;
  localparam logic [2:0] IMM_JALR  = 3'b110;
  localparam logic [2:0] IMM_J     = 3'b111;

  localparam logic [1:0] CAUSE_ECALL   = 2'd0;
  localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
  localparam logic [1:0] CAUSE_BUS     = 2'd3;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts un-acknowledged cycles of a memory transfer and flags the cycle in
// which the count would reach TIMEOUT. TIMEOUT of 0 never expires.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count;

  // Leaving a wait state or completing the transfer restarts the count, so
  // every entry into FETCH/MEMRD/MEMWR begins at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!active || ack) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // An ack in the expiring cycle suppresses the timeout.
  assign expired = (TIMEOUT != 0) && active && !ack && (count == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle RV32I datapath with memory
// wait-state timeout and trap reporting.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter bit ENABLE_SYSTEM = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_memAck,
  input  logic       i_branchTaken,
  output logic       o_memReq,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_pcWrite,
  output logic       o_regWrite,
  output logic [1:0] o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic [1:0] o_ALUOp,
  output logic [1:0] o_resultSrc,
  output logic [2:0] o_immSrc,
  output logic       o_isLoadSigned,
  output logic       o_trap,
  output logic [1:0] o_trapCause,
  output logic [3:0] o_state
);

  state_t     state, state_next;
  logic [1:0] cause, cause_next;
  logic       expired;

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .active (is_wait_state(state)),
    .ack    (i_memAck),
    .expired(expired)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_FETCH;
      cause <= CAUSE_ECALL;
    end else begin
      state <= state_next;
      cause <= cause_next;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause;
    case (state)
      S_FETCH: begin
        if (i_memAck) begin
          state_next = S_DECODE;
        end else if (expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_BUS;
        end
      end
      S_DECODE: begin
        case (i_opcode)
          OPC_LOAD, OPC_STORE: state_next = S_MEMADR;
          OPC_OP:              state_next = S_EXEC_R;
          OPC_OP_IMM:          state_next = S_EXEC_I;
          OPC_BRANCH:          state_next = S_BRANCH;
          OPC_JAL:             state_next = S_JAL;
          OPC_JALR:            state_next = S_JALR;
          OPC_LUI, OPC_AUIPC:  state_next = S_UPPER;
          // ebreak differs from ecall only in imm bits this unit never sees,
          // so funct3=0 reports as ecall and CSR forms as illegal.
          OPC_SYSTEM: begin
            state_next = ENABLE_SYSTEM ? S_TRAP : S_FETCH;
            cause_next = (i_funct3 == 3'b000) ? CAUSE_ECALL : CAUSE_ILLEGAL;
          end
          default: begin
            state_next = ENABLE_SYSTEM ? S_TRAP : S_FETCH;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_next = (i_opcode == OPC_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (i_memAck) begin
          state_next = S_MEMWB;
        end else if (expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_BUS;
        end
      end
      S_MEMWR: begin
        if (i_memAck) begin
          state_next = S_FETCH;
        end else if (expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_BUS;
        end
      end
      S_EXEC_R, S_EXEC_I: state_next = S_ALUWB;
      default:            state_next = S_FETCH;
    endcase
  end

  always_comb begin
    o_memReq    = 1'b0;
    o_memWrite  = 1'b0;
    o_irWrite   = 1'b0;
    o_pcWrite   = 1'b0;
    o_regWrite  = 1'b0;
    o_ALUSrcA   = SRCA_PC;
    o_ALUSrcB   = SRCB_RS2;
    o_ALUOp     = ALUOP_ADD;
    o_resultSrc = RES_ALU;
    o_immSrc    = IMM_NONE;
    o_trap      = 1'b0;
    o_trapCause = CAUSE_ECALL;
    case (state)
      S_FETCH: begin
        o_memReq  = 1'b1;
        o_irWrite = i_memAck;
        o_pcWrite = i_memAck;
        o_ALUSrcB = SRCB_FOUR;
      end
      S_MEMADR: begin
        o_ALUSrcA = SRCA_RS1;
        o_ALUSrcB = SRCB_IMM;
        o_immSrc  = (i_opcode == OPC_LOAD) ? IMM_I : IMM_S;
      end
      S_MEMRD: o_memReq = 1'b1;
      S_MEMWB: begin
        o_regWrite  = 1'b1;
        o_resultSrc = RES_MEM;
      end
      S_MEMWR: begin
        o_memReq   = 1'b1;
        o_memWrite = 1'b1;
      end
      S_EXEC_R: begin
        o_ALUSrcA = SRCA_RS1;
        o_ALUOp   = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        o_ALUSrcA = SRCA_RS1;
        o_ALUSrcB = SRCB_IMM;
        o_ALUOp   = ALUOP_FUNCT;
        o_immSrc  = (i_funct3[1:0] == 2'b01) ? IMM_SHAMT : IMM_I;
      end
      S_ALUWB: o_regWrite = 1'b1;
      S_BRANCH: begin
        o_ALUSrcA = SRCA_RS1;
        o_ALUOp   = ALUOP_BRANCH;
        o_immSrc  = IMM_B;
        o_pcWrite = i_branchTaken;
      end
      S_JAL: begin
        o_ALUSrcA   = SRCA_OLDPC;
        o_ALUSrcB   = SRCB_IMM;
        o_immSrc    = IMM_J;
        o_pcWrite   = 1'b1;
        o_regWrite  = 1'b1;
        o_resultSrc = RES_LINK;
      end
      S_JALR: begin
        o_ALUSrcA   = SRCA_RS1;
        o_ALUSrcB   = SRCB_IMM;
        o_immSrc    = IMM_JALR;
        o_pcWrite   = 1'b1;
        o_regWrite  = 1'b1;
        o_resultSrc = RES_LINK;
      end
      S_UPPER: begin
        o_ALUSrcA   = SRCA_OLDPC;
        o_ALUSrcB   = SRCB_IMM;
        o_immSrc    = IMM_U;
        o_regWrite  = 1'b1;
        o_resultSrc = RES_IMM;
      end
      S_TRAP: begin
        o_trap      = 1'b1;
        o_trapCause = cause;
      end
      default: ;
    endcase
  end

  assign o_isLoadSigned = ~i_funct3[2];
  assign o_state        = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table on the default
// instance plus hand sequences for timeout, system-op and reset corner cases.
module tb_multicycle_control;

  localparam int NI = 3;

  localparam logic [6:0] OP_ADD = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_OPI = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MB = 4'd4;
  localparam logic [3:0] S_MW = 4'd5, S_ER = 4'd6, S_EI = 4'd7, S_AW = 4'd8, S_BR = 4'd9;
  localparam logic [3:0] S_JL = 4'd10, S_JR = 4'd11, S_UP = 4'd12, S_TR = 4'd13;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       ack = 1'b0;
  logic       taken = 1'b0;

  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: MEM_TIMEOUT=4. Instance 2: ENABLE_SYSTEM=0.
  wire [NI-1:0][23:0] ob;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int T = (g == 1) ? 4 : 16;
    localparam bit E = (g != 2);
    multicycle_control #(.MEM_TIMEOUT(T), .ENABLE_SYSTEM(E)) u_dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_opcode      (opcode),
      .i_funct3      (funct3),
      .i_memAck      (ack),
      .i_branchTaken (taken),
      .o_memReq      (ob[g][23]),
      .o_memWrite    (ob[g][22]),
      .o_irWrite     (ob[g][21]),
      .o_pcWrite     (ob[g][20]),
      .o_regWrite    (ob[g][19]),
      .o_ALUSrcA     (ob[g][18:17]),
      .o_ALUSrcB     (ob[g][16:15]),
      .o_ALUOp       (ob[g][14:13]),
      .o_resultSrc   (ob[g][12:11]),
      .o_immSrc      (ob[g][10:8]),
      .o_isLoadSigned(ob[g][7]),
      .o_trap        (ob[g][6]),
      .o_trapCause   (ob[g][5:4]),
      .o_state       (ob[g][3:0])
    );
  end

  // {state, memReq,memWrite,irWrite,pcWrite,regWrite, aluOp, resultSrc, immSrc, loadSigned, trap, cause}
  function automatic logic [19:0] sig(input logic [23:0] o);
    return {o[3:0], o[23:19], o[14:13], o[12:11], o[10:8], o[7], o[6], o[5:4]};
  endfunction

  // scoreboard
  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        a;
    logic        tk;
    logic [19:0] exp;
  } vec_t;

  vec_t        vec_q[$];
  logic [19:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_in(input logic [6:0] o, input logic [2:0] f, input logic a, input logic tk);
    opcode = o;
    funct3 = f;
    ack    = a;
    taken  = tk;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(OP_ADD, 3'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input logic [6:0] o, input logic [2:0] f, input logic a, input logic tk,
                     input logic [3:0] st, input logic [4:0] strb, input logic [1:0] aop,
                     input logic [1:0] res, input logic [2:0] imm, input logic ls,
                     input logic tr, input logic [1:0] cs);
    vec_t v;
    v.opc = o;
    v.f3  = f;
    v.a   = a;
    v.tk  = tk;
    v.exp = {st, strb, aop, res, imm, ls, tr, cs};
    vec_q.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;

    // add: reset state, ack on the first fetch cycle
    add(OP_ADD, 3'd0, 1'b0, 1'b0, S_F,  5'b10000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_ADD, 3'd0, 1'b1, 1'b0, S_F,  5'b10110, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_ADD, 3'd0, 1'b0, 1'b0, S_D,  5'b00000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_ADD, 3'd0, 1'b0, 1'b0, S_ER, 5'b00000, 2'd2, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_ADD, 3'd0, 1'b0, 1'b0, S_AW, 5'b00001, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    // lw, ack on the fourth MEMRD cycle
    add(OP_LW,  3'd2, 1'b1, 1'b0, S_F,  5'b10110, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_LW,  3'd2, 1'b0, 1'b0, S_D,  5'b00000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_LW,  3'd2, 1'b0, 1'b0, S_MA, 5'b00000, 2'd0, 2'd0, 3'd1, 1'b1, 1'b0, 2'd0);
    add(OP_LW,  3'd2, 1'b0, 1'b0, S_MR, 5'b10000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_LW,  3'd2, 1'b0, 1'b0, S_MR, 5'b10000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_LW,  3'd2, 1'b0, 1'b0, S_MR, 5'b10000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_LW,  3'd2, 1'b1, 1'b0, S_MR, 5'b10000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_LW,  3'd2, 1'b0, 1'b0, S_MB, 5'b00001, 2'd0, 2'd1, 3'd0, 1'b1, 1'b0, 2'd0);
    // beq not taken, then taken
    add(OP_BEQ, 3'd0, 1'b1, 1'b0, S_F,  5'b10110, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_BEQ, 3'd0, 1'b0, 1'b0, S_D,  5'b00000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_BEQ, 3'd0, 1'b0, 1'b0, S_BR, 5'b00000, 2'd1, 2'd0, 3'd5, 1'b1, 1'b0, 2'd0);
    add(OP_BEQ, 3'd0, 1'b1, 1'b1, S_F,  5'b10110, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_BEQ, 3'd0, 1'b0, 1'b1, S_D,  5'b00000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_BEQ, 3'd0, 1'b0, 1'b1, S_BR, 5'b00010, 2'd1, 2'd0, 3'd5, 1'b1, 1'b0, 2'd0);
    // slli (shift immediate) then addi
    add(OP_OPI, 3'd1, 1'b1, 1'b0, S_F,  5'b10110, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_OPI, 3'd1, 1'b0, 1'b0, S_D,  5'b00000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_OPI, 3'd1, 1'b0, 1'b0, S_EI, 5'b00000, 2'd2, 2'd0, 3'd2, 1'b1, 1'b0, 2'd0);
    add(OP_OPI, 3'd1, 1'b0, 1'b0, S_AW, 5'b00001, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_OPI, 3'd0, 1'b1, 1'b0, S_F,  5'b10110, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_OPI, 3'd0, 1'b0, 1'b0, S_D,  5'b00000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_OPI, 3'd0, 1'b0, 1'b0, S_EI, 5'b00000, 2'd2, 2'd0, 3'd1, 1'b1, 1'b0, 2'd0);
    add(OP_OPI, 3'd0, 1'b0, 1'b0, S_AW, 5'b00001, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    // ecall traps with cause 0
    add(OP_SYS, 3'd0, 1'b1, 1'b0, S_F,  5'b10110, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_SYS, 3'd0, 1'b0, 1'b0, S_D,  5'b00000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_SYS, 3'd0, 1'b0, 1'b0, S_TR, 5'b00000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 2'd0);
    // jal (funct3=100 drives loadSigned low), jalr, lui
    add(OP_JAL, 3'd4, 1'b1, 1'b0, S_F,  5'b10110, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0);
    add(OP_JAL, 3'd4, 1'b0, 1'b0, S_D,  5'b00000, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0);
    add(OP_JAL, 3'd4, 1'b0, 1'b0, S_JL, 5'b00011, 2'd0, 2'd3, 3'd7, 1'b0, 1'b0, 2'd0);
    add(OP_JLR, 3'd0, 1'b1, 1'b0, S_F,  5'b10110, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_JLR, 3'd0, 1'b0, 1'b0, S_D,  5'b00000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_JLR, 3'd0, 1'b0, 1'b0, S_JR, 5'b00011, 2'd0, 2'd3, 3'd6, 1'b1, 1'b0, 2'd0);
    add(OP_LUI, 3'd0, 1'b1, 1'b0, S_F,  5'b10110, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_LUI, 3'd0, 1'b0, 1'b0, S_D,  5'b00000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_LUI, 3'd0, 1'b0, 1'b0, S_UP, 5'b00001, 2'd0, 2'd2, 3'd4, 1'b1, 1'b0, 2'd0);
    // illegal opcode traps with cause 2, trap lasts one cycle
    add(OP_BAD, 3'd0, 1'b1, 1'b0, S_F,  5'b10110, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_BAD, 3'd0, 1'b0, 1'b0, S_D,  5'b00000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);
    add(OP_BAD, 3'd0, 1'b0, 1'b0, S_TR, 5'b00000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 2'd2);
    add(OP_ADD, 3'd0, 1'b0, 1'b0, S_F,  5'b10000, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 2'd0);

    do_reset();
    for (int i = 0; i < vec_q.size(); i++) begin
      set_in(vec_q[i].opc, vec_q[i].f3, vec_q[i].a, vec_q[i].tk);
      exp_q.push_back(vec_q[i].exp);
      #1;
      check($sformatf("vec[%0d]", i), 32'(sig(ob[0])), 32'(exp_q.pop_front()));
      @(negedge clk);
    end

    // ecall with and without system support
    do_reset();
    set_in(OP_SYS, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    set_in(OP_SYS, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("ecall_sys1_state", 32'(ob[0][3:0]), 32'(S_TR));
    check("ecall_sys1_trap", 32'({ob[0][6], ob[0][5:4]}), 32'(3'b100));
    check("ecall_sys0_state", 32'(ob[2][3:0]), 32'(S_F));
    check("ecall_sys0_trap", 32'(ob[2][6]), 32'(1'b0));
    @(negedge clk);
    #1;
    check("ecall_trap_one_cycle", 32'({ob[0][3:0], ob[0][6]}), 32'({S_F, 1'b0}));

    // store never acked on the MEM_TIMEOUT=4 instance
    do_reset();
    set_in(OP_SW, 3'd2, 1'b1, 1'b0);
    @(negedge clk);
    set_in(OP_SW, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("sw_memadr", 32'({ob[1][3:0], ob[1][18:15], ob[1][10:8]}), 32'({S_MA, 4'b1001, 3'd3}));
    @(negedge clk);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (ob[1][3:0] == S_TR) break;
      if (ob[1][3:0] == S_MW) begin
        n++;
        check("sw_wait_req_write", 32'(ob[1][23:22]), 32'(2'b11));
      end
      @(negedge clk);
    end
    check("sw_wait_cycles", 32'(n), 32'(4));
    check("sw_timeout_state", 32'(ob[1][3:0]), 32'(S_TR));
    check("sw_timeout_trap", 32'({ob[1][6], ob[1][5:4]}), 32'(3'b111));
    check("sw_timeout_strobes", 32'(ob[1][23:19]), 32'(5'b00000));
    @(negedge clk);
    #1;
    check("sw_after_trap", 32'({ob[1][3:0], ob[1][6]}), 32'({S_F, 1'b0}));

    // ack in the same cycle as the timeout completes the fetch
    do_reset();
    repeat (3) begin
      set_in(OP_ADD, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
    end
    set_in(OP_ADD, 3'd0, 1'b1, 1'b0);
    #1;
    check("ack_at_timeout_fetch", 32'({ob[1][3:0], ob[1][21], ob[1][6]}), 32'({S_F, 1'b1, 1'b0}));
    @(negedge clk);
    set_in(OP_ADD, 3'd0, 1'b0, 1'b0);
    #1;
    check("ack_at_timeout_decode", 32'({ob[1][3:0], ob[1][6]}), 32'({S_D, 1'b0}));

    // reset during a MEMWR wait abandons the store and restarts the counter
    do_reset();
    set_in(OP_SW, 3'd2, 1'b1, 1'b0);
    @(negedge clk);
    set_in(OP_SW, 3'd2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_pre_memwr", 32'(ob[1][3:0]), 32'(S_MW));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_state", 32'({ob[0][3:0], ob[1][3:0]}), 32'({S_F, S_F}));
    check("rst_mid_strobes", 32'({ob[0][23:19], ob[1][23:19]}), 32'({5'b10000, 5'b10000}));
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (ob[1][3:0] == S_TR) break;
      if (ob[1][3:0] == S_F) n++;
      @(negedge clk);
      #1;
    end
    check("rst_counter_cleared", 32'(n), 32'(4));
    check("rst_fetch_timeout_cause", 32'({ob[1][3:0], ob[1][6], ob[1][5:4]}), 32'({S_TR, 1'b1, 2'd3}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: wait-state cycles before bus-error trap; 0 disables the timeout.
REQ-002 SHALL have parameter ENABLE_SYSTEM, default 1: 1 routes ecall/ebreak (opcode 1110011) and illegal opcodes to TRAP; 0 treats them as a no-op that returns to FETCH.
REQ-003 SHALL have ports i_clk  in  1  clock; i_rst_n  in  1  synchronous active-low reset.
REQ-004 SHALL have ports i_opcode  in  7  instruction opcode; i_funct3  in  3  funct3; i_memAck  in  1  memory transfer complete; i_branchTaken  in  1  branch condition true.
REQ-005 SHALL have ports o_memReq, o_memWrite, o_irWrite, o_pcWrite, o_regWrite  out  1 each  datapath strobes.
REQ-006 SHALL have ports o_ALUSrcA, o_ALUSrcB, o_ALUOp, o_resultSrc  out  2 each; o_immSrc  out  3; o_isLoadSigned  out  1 (= ~i_funct3[2]).
REQ-007 SHALL have ports o_trap  out  1  trap pulse; o_trapCause  out  2  (0 ecall, 1 ebreak, 2 illegal, 3 bus error); o_state  out  4  current state.

Function
REQ-008 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, UPPER, TRAP; outputs decode from the registered state only.
REQ-009 FETCH SHALL assert o_memReq and hold it until i_memAck; on the ack cycle it SHALL assert o_irWrite and o_pcWrite (PC+4) and go to DECODE.
REQ-010 DECODE SHALL branch on the opcode: load/store -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111/0010111 -> UPPER; other -> TRAP or FETCH per REQ-002.
REQ-011 MEMADR SHALL go to MEMRD for loads and MEMWR for stores; MEMRD SHALL hold o_memReq until i_memAck, then go to MEMWB (o_regWrite=1, o_resultSrc=01) -> FETCH.
REQ-012 MEMWR SHALL hold o_memReq and o_memWrite until i_memAck, then go to FETCH; o_memWrite SHALL never be 1 without o_memReq.
REQ-013 EXEC_R/EXEC_I SHALL drive o_ALUOp=10 and go to ALUWB (o_regWrite=1, o_resultSrc=00) -> FETCH; EXEC_I SHALL drive o_immSrc=010 when i_funct3[1:0]=01, else 001.
REQ-014 BRANCH SHALL drive o_ALUOp=01 and o_immSrc=101, assert o_pcWrite only if i_branchTaken, then go to FETCH.
REQ-015 JAL/JALR SHALL each assert o_pcWrite and o_regWrite with o_resultSrc=11 (immSrc 111 / 110), then go to FETCH; UPPER SHALL write rd with o_resultSrc=10 and o_immSrc=100.
REQ-016 A wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR and increment each un-acked cycle; on reaching MEM_TIMEOUT (if nonzero) the FSM SHALL go to TRAP with cause 3.
REQ-017 An ack arriving in the same cycle as the timeout SHALL win (normal completion, no trap).
REQ-018 TRAP SHALL pulse o_trap for exactly one cycle with o_trapCause valid, deassert all write strobes, then go to FETCH.
REQ-019 Unused multi-bit controls SHALL be driven to 0, never X.

Reset
REQ-020 While i_rst_n=0 at a rising edge, state SHALL become FETCH, the wait counter 0, and o_memReq the only output driven to 1 after reset is released; reset mid-transfer SHALL abandon the transfer with no write strobe.

Structure
REQ-021 State encoding, opcode constants, ALUOp/immSrc/resultSrc codes and trap causes SHALL live in a shared package rv_ctrl_pkg.
REQ-022 The wait counter with timeout compare SHALL be one sub-module, mem_wait_timer.

Verification
REQ-023 add (0110011), ack on 1st cycle -> FETCH,DECODE,EXEC_R,ALUWB,FETCH; o_regWrite=1 in ALUWB only.
REQ-024 lw, ack delayed 3 cycles in MEMRD -> o_memReq high 4 cycles, o_regWrite pulse in MEMWB, o_isLoadSigned=1.
REQ-025 beq with i_branchTaken=0, then 1 -> o_pcWrite=0, then 1 in BRANCH.
REQ-026 MEM_TIMEOUT=4, store never acked -> TRAP after 4 cycles, o_trapCause=3, o_memWrite falls with the trap.
REQ-027 opcode 1110011 funct3=0 with ENABLE_SYSTEM=1 -> one-cycle o_trap, cause 0; with ENABLE_SYSTEM=0 -> FETCH, no trap.
REQ-028 i_rst_n low during MEMWR wait -> next state FETCH, o_memWrite=0, counter 0.
